// File: rtl/input_event_encoder_if.sv
// Signal bundle between the physical board inputs, the event encoder and the
// virtual-input decoder it drives.
interface input_event_encoder_if;
  logic [3:0]  buttons;   // active-low, idle 1
  logic [17:0] switches;  // active-high, idle 0
  logic        clear;     // resend reset-all on rising edge
  logic [4:0]  number;    // code of the current transaction
  logic        control;   // strobe
  logic        busy;      // high for the whole strobe + gap window

  // Strobe protocol: number is loaded on the same edge control rises and stays
  // stable through STROBE_LEN high cycles and GAP_LEN low cycles (busy high for
  // exactly those cycles); at least one idle cycle with busy low follows before
  // the next strobe. The decoder needs no ready: it must accept every strobe.
  modport master (
    input  buttons, switches, clear,
    output number, control, busy
  );

  modport slave (
    output buttons, switches, clear,
    input  number, control, busy
  );
endinterface

// File: rtl/input_event_encoder.sv
// Turns every change on the 22 board inputs into one number/control toggle for
// the virtual-input decoder, keeping a shadow of the state the decoder holds.
module input_event_encoder #(
  parameter int unsigned STROBE_LEN = 2,
  parameter int unsigned GAP_LEN    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input_event_encoder_if.master bus,
  output logic [1:0]            dbg_state_o
);

  localparam int unsigned N_IN           = 22;
  localparam logic [21:0] DEF            = 22'h00000F;
  localparam logic [4:0]  CODE_RESET_ALL = 5'd31;
  localparam logic [4:0]  LAST_CODE      = 5'd21;
  localparam logic [3:0]  STROBE_LOAD    = 4'(STROBE_LEN - 1);
  localparam logic [3:0]  GAP_LOAD       = 4'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  number_q, number_d;
  logic        control_q, control_d;
  logic        busy_q, busy_d;
  logic [21:0] shadow_q, shadow_d;
  logic [4:0]  rr_ptr_q, rr_ptr_d;
  logic        clr_pend_q, clr_pend_d;
  logic        clear_q;
  logic [21:0] sync1_q, sync_vec_q;

  logic [21:0] in_vec;
  logic [21:0] diff;
  logic        clr_rise;
  logic [4:0]  pick_idx;
  logic        pick_vld;

  // Bit i of in_vec is the input whose code is i: buttons[3..0] then switches[17..0].
  assign in_vec   = {{<<{bus.switches}}, {<<{bus.buttons}}};
  assign diff     = sync_vec_q ^ shadow_q;
  assign clr_rise = bus.clear & ~clear_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= DEF;
      sync_vec_q <= DEF;
      clear_q    <= 1'b0;
    end else begin
      sync1_q    <= in_vec;
      sync_vec_q <= sync1_q;
      clear_q    <= bus.clear;
    end
  end

  // Round-robin pick: first set diff bit at or above rr_ptr, wrapping 21 -> 0.
  always_comb begin
    logic [4:0] cand;
    pick_idx = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (rr_ptr_q >= 5'(N_IN - k)) begin
        cand = rr_ptr_q - 5'(N_IN - k);
      end else begin
        cand = rr_ptr_q + 5'(k);
      end
      if (!pick_vld && diff[cand]) begin
        pick_idx = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    number_d   = number_q;
    control_d  = control_q;
    busy_d     = busy_q;
    shadow_d   = shadow_q;
    rr_ptr_d   = rr_ptr_q;
    clr_pend_d = clr_pend_q | clr_rise;

    unique case (state_q)
      ST_IDLE: begin
        if (clr_pend_q) begin
          // A clear edge arriving on this very cycle still queues another reset-all.
          number_d   = CODE_RESET_ALL;
          shadow_d   = DEF;
          clr_pend_d = clr_rise;
          state_d    = ST_STROBE;
          cnt_d      = STROBE_LOAD;
          control_d  = 1'b1;
          busy_d     = 1'b1;
        end else if (pick_vld) begin
          number_d           = pick_idx;
          shadow_d[pick_idx] = ~shadow_q[pick_idx];
          rr_ptr_d           = (pick_idx == LAST_CODE) ? 5'd0 : pick_idx + 5'd1;
          state_d            = ST_STROBE;
          cnt_d              = STROBE_LOAD;
          control_d          = 1'b1;
          busy_d             = 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d   = ST_GAP;
          cnt_d     = GAP_LOAD;
          control_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        control_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      number_q   <= CODE_RESET_ALL;
      control_q  <= 1'b0;
      busy_q     <= 1'b0;
      shadow_q   <= DEF;
      rr_ptr_q   <= '0;
      clr_pend_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      number_q   <= number_d;
      control_q  <= control_d;
      busy_q     <= busy_d;
      shadow_q   <= shadow_d;
      rr_ptr_q   <= rr_ptr_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  assign bus.number  = number_q;
  assign bus.control = control_q;
  assign bus.busy    = busy_q;
  assign dbg_state_o = state_q;

endmodule
